reconf_parser_n: RTL and testbench

- Parametrised, run-time reconfigurable parse-graph walker; one header is resolved per clock.
- Sits between packet-header capture and the match-action pipeline.
- Takes a byte array of the packet header. Emits the byte offset and a valid bit for each configured header type, plus an error flag.
- Number of header types, next-table depth and buffer length are all parameters; loop and overrun protection are included.

---
 rtl/reconf_parser_pkg.sv | 30 +++
 rtl/reconf_parser_n_if.sv | 38 +++
 rtl/reconf_parser_n_next_match.sv | 73 +++++++
 rtl/reconf_parser_n.sv | 201 ++++++++++++++++++++
 tb/tb_reconf_parser_n.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/reconf_parser_pkg.sv
// Shared types and constants for the reconfigurable parse-graph walker.
// Config struct fields are sized to package maxima: ADDR_W <= 16, HID_W <= 8,
// NEXT_TABLE_SIZE <= 8. Modules zero-extend on write and truncate on read.
package reconf_parser_pkg;

    localparam int unsigned TAG_W      = 16;
    localparam int unsigned CFG_ADDR_W = 16;
    localparam int unsigned CFG_HID_W  = 8;
    localparam int unsigned CFG_NEXT_N = 8;

    typedef enum logic [0:0] {
        StIdle,
        StParse
    } state_e;

    typedef struct packed {
        logic [CFG_ADDR_W-1:0]                len;
        logic [CFG_ADDR_W-1:0]                tag_start;
        logic [1:0]                           tag_len;
        logic [CFG_NEXT_N-1:0]                next_valid;
        logic [CFG_NEXT_N-1:0][TAG_W-1:0]     next_tag;
        logic [CFG_NEXT_N-1:0][CFG_HID_W-1:0] next_hdr;
    } hdr_cfg_t;

    // Ids at or beyond the number of header types mean "end of parse".
    function automatic logic NO_HEADER(input logic [31:0] id, input int unsigned num_headers);
        return id >= num_headers;
    endfunction

endpackage

// File: rtl/reconf_parser_n_if.sv
// Bus bundle between the header-capture/control side (master) and the parser (slave).
interface reconf_parser_n_if #(
    parameter int unsigned NUM_HEADERS     = 4,
    parameter int unsigned NEXT_TABLE_SIZE = 4,
    parameter int unsigned HDR_MAX_LEN     = 64,
    parameter int unsigned ADDR_W          = $clog2(HDR_MAX_LEN + 1),
    parameter int unsigned HID_W           = $clog2(NUM_HEADERS + 1)
);

    logic                                   start_i;
    logic [HDR_MAX_LEN-1:0][7:0]            pkt_hdr_i;
    logic                                   busy_o;
    logic                                   ready_o;
    logic                                   error_o;
    logic [NUM_HEADERS-1:0]                 parsed_valid_o;
    logic [NUM_HEADERS-1:0][ADDR_W-1:0]     parsed_offs_o;
    logic                                   cfg_we_i;
    logic [HID_W-1:0]                       cfg_hdr_id_i;
    logic [ADDR_W-1:0]                      cfg_hdr_len_i;
    logic [ADDR_W-1:0]                      cfg_tag_start_i;
    logic [1:0]                             cfg_tag_len_i;
    logic [NEXT_TABLE_SIZE-1:0]             cfg_next_valid_i;
    logic [NEXT_TABLE_SIZE-1:0][15:0]       cfg_next_tag_i;
    logic [NEXT_TABLE_SIZE-1:0][HID_W-1:0]  cfg_next_hdr_i;

    modport master (
        output start_i, pkt_hdr_i, cfg_we_i, cfg_hdr_id_i, cfg_hdr_len_i, cfg_tag_start_i,
               cfg_tag_len_i, cfg_next_valid_i, cfg_next_tag_i, cfg_next_hdr_i,
        input  busy_o, ready_o, error_o, parsed_valid_o, parsed_offs_o
    );

    modport slave (
        input  start_i, pkt_hdr_i, cfg_we_i, cfg_hdr_id_i, cfg_hdr_len_i, cfg_tag_start_i,
               cfg_tag_len_i, cfg_next_valid_i, cfg_next_tag_i, cfg_next_hdr_i,
        output busy_o, ready_o, error_o, parsed_valid_o, parsed_offs_o
    );

endinterface

// File: rtl/reconf_parser_n_next_match.sv
// parser_next_match: combinational tag extraction and lowest-index priority match
// for the header currently being walked. Also flags tag bytes past the buffer end.
module parser_next_match
    import reconf_parser_pkg::*;
#(
    parameter int unsigned NEXT_TABLE_SIZE = 4,
    parameter int unsigned HDR_MAX_LEN     = 64,
    parameter int unsigned ADDR_W          = $clog2(HDR_MAX_LEN + 1),
    parameter int unsigned HID_W           = 3
) (
    input  logic [HDR_MAX_LEN-1:0][7:0]           pkt_hdr_i,
    input  logic [ADDR_W-1:0]                     addr_i,
    input  logic [ADDR_W-1:0]                     tag_start_i,
    input  logic [1:0]                            tag_len_i,
    input  logic [NEXT_TABLE_SIZE-1:0]            next_valid_i,
    input  logic [NEXT_TABLE_SIZE-1:0][TAG_W-1:0] next_tag_i,
    input  logic [NEXT_TABLE_SIZE-1:0][HID_W-1:0] next_hdr_i,
    output logic                                  hit_o,
    output logic [HID_W-1:0]                      next_hdr_o,
    output logic                                  bounds_fault_o
);

    // Two extra bits: addr + tag_start + 2 can reach 2^(ADDR_W+1) at the extremes.
    localparam int unsigned PW = ADDR_W + 2;

    logic [PW-1:0]    pos0;
    logic [PW-1:0]    pos1;
    logic [PW-1:0]    tag_end;
    logic [1:0]       tag_bytes;
    logic [7:0]       byte0;
    logic [7:0]       byte1;
    logic [TAG_W-1:0] tag;

    // Tag byte positions and bounds check; tag_len 3 is treated as a 2-byte tag.
    always_comb begin
        tag_bytes      = (tag_len_i == 2'd3) ? 2'd2 : tag_len_i;
        pos0           = PW'(addr_i) + PW'(tag_start_i);
        pos1           = pos0 + PW'(1);
        tag_end        = pos0 + PW'(tag_bytes);
        bounds_fault_o = (tag_bytes != 2'd0) && (tag_end > PW'(HDR_MAX_LEN));
    end

    // Byte fetch as a compare-mux so out-of-range positions read as zero.
    always_comb begin
        byte0 = '0;
        byte1 = '0;
        for (int i = 0; i < HDR_MAX_LEN; i++) begin
            if (pos0 == PW'(i)) byte0 = pkt_hdr_i[i];
            if (pos1 == PW'(i)) byte1 = pkt_hdr_i[i];
        end
    end

    // Assemble the tag: 1 byte is zero-extended, 2 bytes are big-endian.
    always_comb begin
        if (tag_bytes == 2'd1) tag = {8'h00, byte0};
        else                   tag = {byte0, byte1};
    end

    // Scan high to low so the lowest-indexed matching entry is the last to assign.
    always_comb begin
        hit_o      = 1'b0;
        next_hdr_o = '0;
        if (tag_bytes != 2'd0 && !bounds_fault_o) begin
            for (int i = NEXT_TABLE_SIZE - 1; i >= 0; i--) begin
                if (next_valid_i[i] && next_tag_i[i] == tag) begin
                    hit_o      = 1'b1;
                    next_hdr_o = next_hdr_i[i];
                end
            end
        end
    end

endmodule

// File: rtl/reconf_parser_n.sv
// reconf_parser_n: run-time reconfigurable parse-graph walker, one header per clock.
// Optional build macro RECONF_PARSER_STATS_EN adds saturating packet/error counters.
module reconf_parser_n
    import reconf_parser_pkg::*;
#(
    parameter int unsigned NUM_HEADERS     = 4,
    parameter int unsigned NEXT_TABLE_SIZE = 4,
    parameter int unsigned HDR_MAX_LEN     = 64,
    parameter int unsigned ADDR_W          = $clog2(HDR_MAX_LEN + 1),
    parameter int unsigned HID_W           = $clog2(NUM_HEADERS + 1)
) (
    input logic              clk,
    input logic              rst,
    reconf_parser_n_if.slave bus
`ifdef RECONF_PARSER_STATS_EN
    ,
    output logic [31:0]      pkt_cnt_o,
    output logic [31:0]      err_cnt_o
`endif
);

    localparam int unsigned AW1 = ADDR_W + 1;

    state_e                             state_q;
    logic [HID_W-1:0]                   hdr_id_q;
    logic [ADDR_W-1:0]                  addr_q;
    logic [HID_W-1:0]                   step_q;
    logic                               busy_q;
    logic                               ready_q;
    logic                               error_q;
    logic [NUM_HEADERS-1:0]             valid_q;
    logic [NUM_HEADERS-1:0][ADDR_W-1:0] offs_q;
    hdr_cfg_t                           cfg_q [NUM_HEADERS];

    hdr_cfg_t                               cfg_wr;
    hdr_cfg_t                               cur_cfg;
    logic [ADDR_W-1:0]                      cur_len;
    logic [ADDR_W-1:0]                      cur_tag_start;
    logic [NEXT_TABLE_SIZE-1:0]             cur_next_valid;
    logic [NEXT_TABLE_SIZE-1:0][TAG_W-1:0]  cur_next_tag;
    logic [NEXT_TABLE_SIZE-1:0][HID_W-1:0]  cur_next_hdr;
    logic [NUM_HEADERS-1:0]                 cur_sel;
    logic [NUM_HEADERS-1:0]                 next_sel;
    logic                                   m_hit;
    logic [HID_W-1:0]                       m_next;
    logic                                   m_bounds;
    logic [AW1-1:0]                         addr_end;
    logic                                   in_parse;
    logic                                   hdr_fault;
    logic                                   parse_end;
    logic                                   loop_hit;
    logic                                   fin_ok;
    logic                                   fin_err;

    // Widen the incoming config write into the stored struct layout.
    always_comb begin
        cfg_wr           = '0;
        cfg_wr.len       = CFG_ADDR_W'(bus.cfg_hdr_len_i);
        cfg_wr.tag_start = CFG_ADDR_W'(bus.cfg_tag_start_i);
        cfg_wr.tag_len   = bus.cfg_tag_len_i;
        for (int i = 0; i < NEXT_TABLE_SIZE; i++) begin
            cfg_wr.next_valid[i] = bus.cfg_next_valid_i[i];
            cfg_wr.next_tag[i]   = bus.cfg_next_tag_i[i];
            cfg_wr.next_hdr[i]   = CFG_HID_W'(bus.cfg_next_hdr_i[i]);
        end
    end

    // Config table: written only in IDLE; out-of-range ids match no entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int h = 0; h < NUM_HEADERS; h++) cfg_q[h] <= '0;
        end else if (state_q == StIdle && bus.cfg_we_i) begin
            for (int h = 0; h < NUM_HEADERS; h++) begin
                if (bus.cfg_hdr_id_i == HID_W'(h)) cfg_q[h] <= cfg_wr;
            end
        end
    end

    // Select the current header's config and narrow it to the working widths.
    always_comb begin
        cur_cfg = '0;
        for (int h = 0; h < NUM_HEADERS; h++) begin
            cur_sel[h] = (hdr_id_q == HID_W'(h));
            if (cur_sel[h]) cur_cfg = cfg_q[h];
        end
        cur_len       = ADDR_W'(cur_cfg.len);
        cur_tag_start = ADDR_W'(cur_cfg.tag_start);
        for (int i = 0; i < NEXT_TABLE_SIZE; i++) begin
            cur_next_valid[i] = cur_cfg.next_valid[i];
            cur_next_tag[i]   = cur_cfg.next_tag[i];
            cur_next_hdr[i]   = HID_W'(cur_cfg.next_hdr[i]);
        end
    end

    parser_next_match #(
        .NEXT_TABLE_SIZE (NEXT_TABLE_SIZE),
        .HDR_MAX_LEN     (HDR_MAX_LEN),
        .ADDR_W          (ADDR_W),
        .HID_W           (HID_W)
    ) u_next_match (
        .pkt_hdr_i      (bus.pkt_hdr_i),
        .addr_i         (addr_q),
        .tag_start_i    (cur_tag_start),
        .tag_len_i      (cur_cfg.tag_len),
        .next_valid_i   (cur_next_valid),
        .next_tag_i     (cur_next_tag),
        .next_hdr_i     (cur_next_hdr),
        .hit_o          (m_hit),
        .next_hdr_o     (m_next),
        .bounds_fault_o (m_bounds)
    );

    // Per-cycle decision: fault at this header, normal end, loop, or advance.
    always_comb begin
        in_parse  = (state_q == StParse);
        addr_end  = AW1'(addr_q) + AW1'(cur_len);
        hdr_fault = (addr_end > AW1'(HDR_MAX_LEN)) || m_bounds ||
                    (step_q >= HID_W'(NUM_HEADERS));
        parse_end = !m_hit || NO_HEADER(32'(m_next), NUM_HEADERS);
        for (int h = 0; h < NUM_HEADERS; h++) next_sel[h] = (m_next == HID_W'(h));
        // The current header counts as visited even though its valid bit lands this edge.
        loop_hit  = |(next_sel & (valid_q | cur_sel));
        fin_err   = in_parse && (hdr_fault || (!parse_end && loop_hit));
        fin_ok    = in_parse && !hdr_fault && parse_end;
    end

    // Parse FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            hdr_id_q <= '0;
            addr_q   <= '0;
            step_q   <= '0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            error_q  <= 1'b0;
            valid_q  <= '0;
            offs_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start_i && !bus.cfg_we_i) begin
                        state_q  <= StParse;
                        busy_q   <= 1'b1;
                        ready_q  <= 1'b0;
                        error_q  <= 1'b0;
                        valid_q  <= '0;
                        hdr_id_q <= '0;
                        addr_q   <= '0;
                        step_q   <= '0;
                    end
                end
                StParse: begin
                    if (!hdr_fault) begin
                        valid_q <= valid_q | cur_sel;
                        for (int h = 0; h < NUM_HEADERS; h++) begin
                            if (cur_sel[h]) offs_q[h] <= addr_q;
                        end
                    end
                    if (fin_ok || fin_err) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        error_q <= fin_err;
                    end else begin
                        hdr_id_q <= m_next;
                        addr_q   <= addr_end[ADDR_W-1:0];
                        step_q   <= step_q + HID_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy_o         = busy_q;
    assign bus.ready_o        = ready_q;
    assign bus.error_o        = error_q;
    assign bus.parsed_valid_o = valid_q;
    assign bus.parsed_offs_o  = offs_q;

`ifdef RECONF_PARSER_STATS_EN
    logic [31:0] pkt_cnt_q;
    logic [31:0] err_cnt_q;

    // Saturating finish/error counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            if ((fin_ok || fin_err) && pkt_cnt_q != '1) pkt_cnt_q <= pkt_cnt_q + 32'd1;
            if (fin_err && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 32'd1;
        end
    end

    assign pkt_cnt_o = pkt_cnt_q;
    assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_reconf_parser_n.sv
// Directed bench for reconf_parser_n: Eth/IPv4/TCP chain, miss, loop, overrun,
// tag bounds, config/start arbitration and mid-parse reset.
module tb_reconf_parser_n;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    reconf_parser_n_if bus_if ();

`ifdef RECONF_PARSER_STATS_EN
    logic [31:0] pkt_cnt;
    logic [31:0] err_cnt;
`endif

    reconf_parser_n dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if)
`ifdef RECONF_PARSER_STATS_EN
        ,
        .pkt_cnt_o (pkt_cnt),
        .err_cnt_o (err_cnt)
`endif
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_cfg(input int id, input int len, input int ts, input int tl,
                             input logic [3:0] nv, input logic [3:0][15:0] tags,
                             input logic [3:0][2:0] hdrs);
        bus_if.cfg_hdr_id_i     = 3'(id);
        bus_if.cfg_hdr_len_i    = 7'(len);
        bus_if.cfg_tag_start_i  = 7'(ts);
        bus_if.cfg_tag_len_i    = 2'(tl);
        bus_if.cfg_next_valid_i = nv;
        bus_if.cfg_next_tag_i   = tags;
        bus_if.cfg_next_hdr_i   = hdrs;
    endtask

    task automatic cfg_write(input int id, input int len, input int ts, input int tl,
                             input logic [3:0] nv, input logic [3:0][15:0] tags,
                             input logic [3:0][2:0] hdrs);
        drive_cfg(id, len, ts, tl, nv, tags, hdrs);
        bus_if.cfg_we_i = 1'b1;
        tick();
        bus_if.cfg_we_i = 1'b0;
    endtask

    // Cycles from the current point until ready_o, capped at 20.
    task automatic wait_ready(output int lat);
        lat = 0;
        while (lat < 20) begin
            tick();
            lat++;
            if (bus_if.ready_o) break;
        end
    endtask

    task automatic run_parse(input string tag, input int exp_lat, input logic exp_err,
                             input logic [3:0] exp_valid);
        int lat;
        bus_if.start_i = 1'b1;
        tick();
        bus_if.start_i = 1'b0;
        check({tag, "_busy"}, 32'(bus_if.busy_o), 32'd1);
        wait_ready(lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_err"}, 32'(bus_if.error_o), 32'(exp_err));
        check({tag, "_valid"}, 32'(bus_if.parsed_valid_o), 32'(exp_valid));
        check({tag, "_idle"}, 32'(bus_if.busy_o), 32'd0);
    endtask

    initial begin
        int lat;
        rst                     = 1'b1;
        bus_if.start_i          = 1'b0;
        bus_if.cfg_we_i         = 1'b0;
        bus_if.pkt_hdr_i        = '0;
        drive_cfg(0, 0, 0, 0, 4'b0, '0, '0);
        tick();
        tick();
        check("rst_busy", 32'(bus_if.busy_o), 32'd0);
        check("rst_ready", 32'(bus_if.ready_o), 32'd0);
        check("rst_error", 32'(bus_if.error_o), 32'd0);
        check("rst_valid", 32'(bus_if.parsed_valid_o), 32'd0);
        check("rst_offs", 32'(bus_if.parsed_offs_o), 32'd0);
        rst = 1'b0;
        tick();

        // Eth: entry0 disabled, entries 1 and 2 both match 0x0800; entry1 (->1) wins.
        cfg_write(0, 14, 12, 2, 4'b0110, {16'h0000, 16'h0800, 16'h0800, 16'h0800},
                  {3'd0, 3'd2, 3'd1, 3'd3});
        cfg_write(1, 20, 9, 1, 4'b0001, {16'h0, 16'h0, 16'h0, 16'h0006},
                  {3'd0, 3'd0, 3'd0, 3'd2});
        cfg_write(2, 20, 0, 0, 4'b0000, '0, '0);
        bus_if.pkt_hdr_i[12] = 8'h08;
        bus_if.pkt_hdr_i[13] = 8'h00;
        bus_if.pkt_hdr_i[23] = 8'h06;
        run_parse("eth", 3, 1'b0, 4'b0111);
        check("eth_offs0", 32'(bus_if.parsed_offs_o[0]), 32'd0);
        check("eth_offs1", 32'(bus_if.parsed_offs_o[1]), 32'd14);
        check("eth_offs2", 32'(bus_if.parsed_offs_o[2]), 32'd34);

        // Unknown ethertype: ends after the first header.
        bus_if.pkt_hdr_i[12] = 8'h86;
        bus_if.pkt_hdr_i[13] = 8'hDD;
        run_parse("v6", 1, 1'b0, 4'b0001);
        check("v6_offs0", 32'(bus_if.parsed_offs_o[0]), 32'd0);
        bus_if.pkt_hdr_i[12] = 8'h08;
        bus_if.pkt_hdr_i[13] = 8'h00;

        // Loop back to header 0.
        cfg_write(1, 20, 9, 1, 4'b0001, {16'h0, 16'h0, 16'h0, 16'h0006},
                  {3'd0, 3'd0, 3'd0, 3'd0});
        run_parse("loop", 2, 1'b1, 4'b0011);

        // Overrun: 34 + 40 > 64.
        cfg_write(1, 20, 9, 1, 4'b0001, {16'h0, 16'h0, 16'h0, 16'h0006},
                  {3'd0, 3'd0, 3'd0, 3'd2});
        cfg_write(2, 40, 0, 0, 4'b0000, '0, '0);
        run_parse("ovr", 3, 1'b1, 4'b0011);

        // Exact fit: 34 + 30 == 64 is legal.
        cfg_write(2, 30, 0, 0, 4'b0000, '0, '0);
        run_parse("fit", 3, 1'b0, 4'b0111);
        check("fit_offs2", 32'(bus_if.parsed_offs_o[2]), 32'd34);

        // Two-byte tag at 63..64 runs past the buffer.
        cfg_write(0, 14, 63, 2, 4'b0110, {16'h0000, 16'h0800, 16'h0800, 16'h0800},
                  {3'd0, 3'd2, 3'd1, 3'd3});
        run_parse("tagovr", 1, 1'b1, 4'b0000);
        // Tag at 62..63 is in range; bytes are zero so nothing matches.
        cfg_write(0, 14, 62, 2, 4'b0110, {16'h0000, 16'h0800, 16'h0800, 16'h0800},
                  {3'd0, 3'd2, 3'd1, 3'd3});
        run_parse("tagfit", 1, 1'b0, 4'b0001);
        cfg_write(0, 14, 12, 2, 4'b0110, {16'h0000, 16'h0800, 16'h0800, 16'h0800},
                  {3'd0, 3'd2, 3'd1, 3'd3});

        // Config write while busy is ignored.
        bus_if.start_i = 1'b1;
        tick();
        bus_if.start_i = 1'b0;
        drive_cfg(2, 40, 0, 0, 4'b0000, '0, '0);
        bus_if.cfg_we_i = 1'b1;
        tick();
        bus_if.cfg_we_i = 1'b0;
        wait_ready(lat);
        check("busywr_seen", 32'(bus_if.ready_o), 32'd1);
        check("busywr_err", 32'(bus_if.error_o), 32'd0);
        check("busywr_valid", 32'(bus_if.parsed_valid_o), 32'h7);

        // Write with simultaneous start in IDLE: write lands, start dropped.
        bus_if.cfg_we_i = 1'b1;
        bus_if.start_i  = 1'b1;
        tick();
        bus_if.cfg_we_i = 1'b0;
        bus_if.start_i  = 1'b0;
        check("drop_busy", 32'(bus_if.busy_o), 32'd0);
        check("drop_ready", 32'(bus_if.ready_o), 32'd1);
        run_parse("landed", 3, 1'b1, 4'b0011);

        // Reset during the second PARSE cycle.
        cfg_write(2, 20, 0, 0, 4'b0000, '0, '0);
        bus_if.start_i = 1'b1;
        tick();
        bus_if.start_i = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("mrst_busy", 32'(bus_if.busy_o), 32'd0);
        check("mrst_ready", 32'(bus_if.ready_o), 32'd0);
        check("mrst_error", 32'(bus_if.error_o), 32'd0);
        check("mrst_valid", 32'(bus_if.parsed_valid_o), 32'd0);
        check("mrst_offs", 32'(bus_if.parsed_offs_o), 32'd0);
        rst = 1'b0;
        tick();
        // Cleared config: header 0 has length 0 and no tag, so parsing stops there.
        run_parse("postrst", 1, 1'b0, 4'b0001);
        check("postrst_offs0", 32'(bus_if.parsed_offs_o[0]), 32'd0);
`ifdef RECONF_PARSER_STATS_EN
        check("stats_pkt", pkt_cnt, 32'd1);
        check("stats_err", err_cnt, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
